mem_read_arbiter: RTL

- Shares the single AXI-style memory read channel (axi_read_address / axi_read_data) between the instruction cache and the data cache refill engines.
- Grants one requester at a time and forwards its address phase to memory.
- Routes the returning data beats to the granted requester, counting them against the latched burst length, then re-arbitrates.
- Sits between the two caches and the top-level memory port.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/axi_read_if.sv | 19 +
 rtl/arb_grant2.sv | 18 +
 rtl/mem_read_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, requester-id types and constants for the memory read arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_e;
  typedef logic arb_id_t;
  localparam arb_id_t ARB_ID_ICACHE = 1'b0;
  localparam arb_id_t ARB_ID_DCACHE = 1'b1;
endpackage

// File: rtl/axi_read_if.sv
// axi_read_if: AXI-style read address and read data channel interfaces
interface axi_read_address;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARID;
  modport master (output ARVALID, ARADDR, ARLEN, ARID, input ARREADY);
  modport slave  (input ARVALID, ARADDR, ARLEN, ARID, output ARREADY);
endinterface

interface axi_read_data;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic        RID;
  modport master (input RVALID, RDATA, RID, output RREADY);
  modport slave  (output RVALID, RDATA, RID, input RREADY);
endinterface

// File: rtl/arb_grant2.sv
// arb_grant2: two-way grant; fixed dcache priority, or round-robin when MEM_ARB_ROUND_ROBIN_EN is defined
module arb_grant2
  import mem_arb_pkg::*;
(
  input  logic    req0_i,
  input  logic    req1_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  arb_id_t ptr_i,
`endif
  output arb_id_t gnt_o
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign gnt_o = (req0_i && req1_i) ? ptr_i : (req1_i ? ARB_ID_DCACHE : ARB_ID_ICACHE);
`else
  // with no request the result is unused, so dcache wins unless only icache asks
  assign gnt_o = (req1_i || !req0_i) ? ARB_ID_DCACHE : ARB_ID_ICACHE;
`endif
endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI read channel between icache (0) and dcache (1); MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed dcache priority
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LEN_WIDTH     = 5,
  parameter int DATA_BEAT_MAX = 16
) (
  input logic              clk,
  input logic              rst_n,
  axi_read_address.slave   icache_ar,
  axi_read_data.slave      icache_r,
  axi_read_address.slave   dcache_ar,
  axi_read_data.slave      dcache_r,
  axi_read_address.master  mem_ar,
  axi_read_data.master     mem_r
);
  arb_state_e           state_q, state_d;
  arb_id_t              owner_q, owner_d, gnt;
  logic [31:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, last_idx, req_len;
  logic [7:0]           raw_len;
  logic                 req_any, ar_hs, beat, own_rready, in_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_id_t              ptr_q, ptr_d;
`endif

  arb_grant2 u_grant (
    .req0_i (icache_ar.ARVALID),
    .req1_i (dcache_ar.ARVALID),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .ptr_i  (ptr_q),
`endif
    .gnt_o  (gnt)
  );

  assign req_any    = icache_ar.ARVALID || dcache_ar.ARVALID;
  assign raw_len    = gnt ? dcache_ar.ARLEN : icache_ar.ARLEN;
  assign req_len    = (raw_len > 8'(DATA_BEAT_MAX)) ? LEN_WIDTH'(DATA_BEAT_MAX) : raw_len[LEN_WIDTH-1:0];
  // ARLEN counts beats; zero still moves one beat
  assign last_idx   = (len_q == '0) ? '0 : len_q - LEN_WIDTH'(1);
  assign in_data    = state_q == ARB_DATA;
  assign ar_hs      = (state_q == ARB_ADDR) && mem_ar.ARREADY;
  assign own_rready = owner_q ? dcache_r.RREADY : icache_r.RREADY;
  assign beat       = in_data && mem_r.RVALID && own_rready;

  assign mem_ar.ARVALID    = state_q == ARB_ADDR;
  assign mem_ar.ARADDR     = addr_q;
  assign mem_ar.ARLEN      = 8'(len_q);
  assign mem_ar.ARID       = owner_q;
  assign icache_ar.ARREADY = ar_hs && (owner_q == ARB_ID_ICACHE);
  assign dcache_ar.ARREADY = ar_hs && (owner_q == ARB_ID_DCACHE);
  assign mem_r.RREADY      = in_data && own_rready;
  assign icache_r.RVALID   = in_data && mem_r.RVALID && (owner_q == ARB_ID_ICACHE);
  assign dcache_r.RVALID   = in_data && mem_r.RVALID && (owner_q == ARB_ID_DCACHE);
  assign icache_r.RDATA    = mem_r.RDATA;
  assign dcache_r.RDATA    = mem_r.RDATA;
  assign icache_r.RID      = mem_r.RID;
  assign dcache_r.RID      = mem_r.RID;

  // next state: latch a grant in IDLE, issue in ADDR, count owner beats in DATA
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ARB_IDLE: if (req_any) begin
        state_d = ARB_ADDR;
        owner_d = gnt;
        addr_d  = gnt ? dcache_ar.ARADDR : icache_ar.ARADDR;
        len_d   = req_len;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d   = ~gnt;
`endif
      end
      ARB_ADDR: if (ar_hs) begin
        state_d = ARB_DATA;
        cnt_d   = '0;
      end
      ARB_DATA: if (beat) begin
        cnt_d   = cnt_q + LEN_WIDTH'(1);
        state_d = (cnt_q == last_idx) ? ARB_IDLE : ARB_DATA;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // state and latched request; reset abandons any in-flight burst
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_ID_ICACHE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // round-robin preference pointer
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= ARB_ID_ICACHE;
    else        ptr_q <= ptr_d;
  end
`endif
endmodule
